hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl_pkg.sv | 87 ++++++++
 rtl/hazard_ctrl_if.sv | 34 +++
 rtl/hazard_ctrl_tag_pipe.sv | 69 ++++++
 rtl/hazard_ctrl.sv | 110 +++++++++++
 tb/tb_hazard_ctrl.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_pkg
// Shared definitions for the pipeline hazard controller.
//   - opcode constants and instruction class encodings
//   - controller state encoding (RUN/RAW/MEM/FLUSH)
//   - scoreboard tag and decoded-operand structures
//   - decode and saturating-increment helpers
// No ports (package).
// -----------------------------------------------------------------------------
package hazard_ctrl_pkg;

  localparam logic [5:0]  OP_LW   = 6'b01_0000;
  localparam logic [5:0]  OP_SW   = 6'b01_0001;
  localparam logic [5:0]  OP_BEQ  = 6'b10_0000;
  localparam logic [5:0]  OP_JMP  = 6'b10_0001;
  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  typedef enum logic [2:0] {
    CLS_NOP = 3'd0,
    CLS_ALU = 3'd1,
    CLS_LW  = 3'd2,
    CLS_SW  = 3'd3,
    CLS_BEQ = 3'd4,
    CLS_JMP = 3'd5
  } instr_class_e;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_RAW   = 2'd1,
    ST_MEM   = 2'd2,
    ST_FLUSH = 2'd3
  } hz_state_e;

  // Scoreboard entry: destination register of the instruction in a stage.
  typedef struct packed {
    logic       valid;
    logic [4:0] rnum;
  } reg_tag_t;

  typedef struct packed {
    logic       src_a_vld;
    logic [4:0] src_a;
    logic       src_b_vld;
    logic [4:0] src_b;
    logic       dst_vld;
    logic [4:0] dst;
  } decode_t;

  function automatic instr_class_e classify(input logic [5:0] op);
    instr_class_e cls;
    cls = CLS_NOP;
    if (op[5:4] == 2'b00)  cls = CLS_ALU;
    else if (op == OP_LW)  cls = CLS_LW;
    else if (op == OP_SW)  cls = CLS_SW;
    else if (op == OP_BEQ) cls = CLS_BEQ;
    else if (op == OP_JMP) cls = CLS_JMP;
    return cls;
  endfunction

  // Extract which register fields an instruction reads and writes.
  function automatic decode_t decode_instr(input logic [31:0] ir);
    decode_t d;
    d = '0;
    case (classify(ir[31:26]))
      CLS_ALU: begin
        d.src_a_vld = 1'b1; d.src_a = ir[20:16];
        d.src_b_vld = 1'b1; d.src_b = ir[15:11];
        d.dst_vld   = 1'b1; d.dst   = ir[25:21];
      end
      CLS_LW: begin
        d.src_a_vld = 1'b1; d.src_a = ir[20:16];
        d.dst_vld   = 1'b1; d.dst   = ir[25:21];
      end
      CLS_SW, CLS_BEQ: begin
        d.src_a_vld = 1'b1; d.src_a = ir[25:21];
        d.src_b_vld = 1'b1; d.src_b = ir[20:16];
      end
      default: ;
    endcase
    return d;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == CNT_MAX) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_if
// Bundle between the pipeline datapath (master) and the hazard controller
// (slave).
//   master drives : ir_id, id_valid, br_taken, mem_busy
//   slave drives  : pc_we, ifid_we, ifid_flush, idex_bubble, back_we,
//                   state, stall_cnt, flush_cnt
// -----------------------------------------------------------------------------
interface hazard_ctrl_if;
  logic [31:0] ir_id;
  logic        id_valid;
  logic        br_taken;
  logic        mem_busy;
  logic        pc_we;
  logic        ifid_we;
  logic        ifid_flush;
  logic        idex_bubble;
  logic        back_we;
  logic [1:0]  state;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;

  modport master (
    output ir_id, id_valid, br_taken, mem_busy,
    input  pc_we, ifid_we, ifid_flush, idex_bubble, back_we,
           state, stall_cnt, flush_cnt
  );

  modport slave (
    input  ir_id, id_valid, br_taken, mem_busy,
    output pc_we, ifid_we, ifid_flush, idex_bubble, back_we,
           state, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl_tag_pipe.sv
// -----------------------------------------------------------------------------
// hazard_tag_pipe
// Three-stage destination-register scoreboard (EX, MEM, WB) with a compare
// port for the two source operands of the instruction in ID.
//   clk, rst_n       : clock, synchronous active-low reset (clears all tags)
//   hold             : freeze all tags for this cycle
//   ex_in            : tag entering EX when not held
//   src_a/_vld,
//   src_b/_vld       : source registers to compare
//   hit              : a valid source matches a hazard-relevant stage tag
// -----------------------------------------------------------------------------
module hazard_tag_pipe
  import hazard_ctrl_pkg::*;
#(
  // Bit order {WB, MEM, EX}. WB is excluded by default because the register
  // file writes on the falling edge, so ID already reads the new value.
  parameter logic [2:0] HAZARD_STAGES = 3'b011
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       hold,
  input  reg_tag_t   ex_in,
  input  logic       src_a_vld,
  input  logic [4:0] src_a,
  input  logic       src_b_vld,
  input  logic [4:0] src_b,
  output logic       hit
);

  reg_tag_t ex_q, mem_q, wb_q;
  reg_tag_t ex_d, mem_d, wb_d;
  logic [2:0] stage_hit;

  function automatic logic tag_match(input reg_tag_t t, input logic vld,
                                     input logic [4:0] src);
    return t.valid && vld && (t.rnum == src);
  endfunction

  always_comb begin
    ex_d  = ex_q;
    mem_d = mem_q;
    wb_d  = wb_q;
    if (!hold) begin
      ex_d  = ex_in;
      mem_d = ex_q;
      wb_d  = mem_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

  always_comb begin
    stage_hit[0] = tag_match(ex_q,  src_a_vld, src_a) | tag_match(ex_q,  src_b_vld, src_b);
    stage_hit[1] = tag_match(mem_q, src_a_vld, src_a) | tag_match(mem_q, src_b_vld, src_b);
    stage_hit[2] = tag_match(wb_q,  src_a_vld, src_a) | tag_match(wb_q,  src_b_vld, src_b);
    hit          = |(stage_hit & HAZARD_STAGES);
  end

endmodule

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Pipeline hazard controller: decides each cycle between a memory freeze,
// a taken-branch flush, a RAW stall, or normal run, drives the pipeline
// latch enables, and keeps saturating stall/flush statistics.
//   clk    : pipeline clock
//   rst_n  : synchronous active-low reset
//   hif    : hazard_ctrl_if.slave (ID instruction and events in, pipeline
//            enables, registered state and counters out)
// -----------------------------------------------------------------------------
module hazard_ctrl
  import hazard_ctrl_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  hazard_ctrl_if.slave  hif
);

  decode_t   dec;
  logic      hit;
  logic      raw;
  reg_tag_t  ex_in;

  logic pc_we, ifid_we, ifid_flush, idex_bubble, back_we;

  hz_state_e   state_q, state_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    dec = decode_instr(hif.ir_id);
    raw = hif.id_valid && hit;
  end

  // Priority decision: reset > mem_busy > br_taken > raw > run.
  always_comb begin
    pc_we       = 1'b1;
    ifid_we     = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    back_we     = 1'b1;
    state_d     = ST_RUN;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!rst_n) begin
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      back_we     = 1'b0;
    end else if (hif.mem_busy) begin
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      back_we     = 1'b0;
      state_d     = ST_MEM;
    end else if (hif.br_taken) begin
      // The ID instruction is squashed, so its own hazard is irrelevant.
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      state_d     = ST_FLUSH;
      flush_cnt_d = sat_inc(flush_cnt_q);
    end else if (raw) begin
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      idex_bubble = 1'b1;
      state_d     = ST_RAW;
      stall_cnt_d = sat_inc(stall_cnt_q);
    end
  end

  always_comb begin
    ex_in.valid = !idex_bubble && hif.id_valid && dec.dst_vld;
    ex_in.rnum  = dec.dst;
  end

  hazard_tag_pipe u_tag_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .hold      (hif.mem_busy),
    .ex_in     (ex_in),
    .src_a_vld (dec.src_a_vld),
    .src_a     (dec.src_a),
    .src_b_vld (dec.src_b_vld),
    .src_b     (dec.src_b),
    .hit       (hit)
  );

  // State is the registered copy of this cycle's decision.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign hif.pc_we       = pc_we;
  assign hif.ifid_we     = ifid_we;
  assign hif.ifid_flush  = ifid_flush;
  assign hif.idex_bubble = idex_bubble;
  assign hif.back_we     = back_we;
  assign hif.state       = state_q;
  assign hif.stall_cnt   = stall_cnt_q;
  assign hif.flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
// Directed bench for hazard_ctrl. Inputs change on the falling edge and
// outputs are sampled 1 time unit later, so registered outputs show the
// decision taken at the preceding rising edge.
// Control vector order: {pc_we, ifid_we, ifid_flush, idex_bubble, back_we}.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  localparam logic [4:0]  CTL_RUN   = 5'b11001;
  localparam logic [4:0]  CTL_RAW   = 5'b00011;
  localparam logic [4:0]  CTL_MEM   = 5'b00000;
  localparam logic [4:0]  CTL_FLUSH = 5'b11111;
  localparam logic [4:0]  CTL_RST   = 5'b00110;
  localparam logic [31:0] NOP_I     = 32'hFC00_0000;

  logic clk;
  logic rst_n;
  int   check_cnt;
  int   err_cnt;

  hazard_ctrl_if hif();

  hazard_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hif   (hif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] alu(input logic [4:0] ri, input logic [4:0] rj,
                                      input logic [4:0] rk);
    return {6'b000000, ri, rj, rk, 11'd0};
  endfunction

  function automatic logic [31:0] sw(input logic [4:0] ri, input logic [4:0] rj);
    return {OP_SW, ri, rj, 16'd0};
  endfunction

  task automatic checkOutput(input string tag, input logic [15:0] actual,
                             input logic [15:0] expected);
    check_cnt++;
    if (actual !== expected) begin
      err_cnt++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  task automatic checkCtl(input string tag, input logic [4:0] expected);
    checkOutput(tag, {11'd0, hif.pc_we, hif.ifid_we, hif.ifid_flush,
                      hif.idex_bubble, hif.back_we}, {11'd0, expected});
  endtask

  task automatic applyStimulus(input logic rst, input logic [31:0] ir,
                               input logic vld, input logic br, input logic mb);
    @(negedge clk);
    rst_n        = rst;
    hif.ir_id    = ir;
    hif.id_valid = vld;
    hif.br_taken = br;
    hif.mem_busy = mb;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, NOP_I, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    check_cnt    = 0;
    err_cnt      = 0;
    rst_n        = 1'b0;
    hif.ir_id    = NOP_I;
    hif.id_valid = 1'b0;
    hif.br_taken = 1'b0;
    hif.mem_busy = 1'b0;

    $display("[TB] reset");
    applyStimulus(1'b0, NOP_I, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, NOP_I, 1'b0, 1'b0, 1'b0);
    checkCtl("rst_ctl", CTL_RST);
    checkOutput("rst_state", {14'd0, hif.state}, 16'd0);
    checkOutput("rst_stall", hif.stall_cnt, 16'd0);
    checkOutput("rst_flush", hif.flush_cnt, 16'd0);

    $display("[TB] back-to-back EX dependency");
    applyStimulus(1'b1, alu(5'd3, 5'd1, 5'd2), 1'b1, 1'b0, 1'b0);
    checkCtl("b2b_issue", CTL_RUN);
    applyStimulus(1'b1, alu(5'd4, 5'd3, 5'd5), 1'b1, 1'b0, 1'b0);
    checkCtl("b2b_stall1", CTL_RAW);
    applyStimulus(1'b1, alu(5'd4, 5'd3, 5'd5), 1'b1, 1'b0, 1'b0);
    checkCtl("b2b_stall2", CTL_RAW);
    checkOutput("b2b_state", {14'd0, hif.state}, 16'd1);
    checkOutput("b2b_cnt1", hif.stall_cnt, 16'd1);
    applyStimulus(1'b1, alu(5'd4, 5'd3, 5'd5), 1'b1, 1'b0, 1'b0);
    checkCtl("b2b_go", CTL_RUN);
    checkOutput("b2b_cnt2", hif.stall_cnt, 16'd2);
    applyStimulus(1'b1, NOP_I, 1'b1, 1'b0, 1'b0);
    checkCtl("b2b_nop", CTL_RUN);
    checkOutput("b2b_state_run", {14'd0, hif.state}, 16'd0);
    idle(3);

    $display("[TB] MEM-stage dependency");
    applyStimulus(1'b1, alu(5'd7, 5'd1, 5'd2), 1'b1, 1'b0, 1'b0);
    checkCtl("mem_issue", CTL_RUN);
    applyStimulus(1'b1, alu(5'd8, 5'd1, 5'd2), 1'b1, 1'b0, 1'b0);
    checkCtl("mem_indep", CTL_RUN);
    applyStimulus(1'b1, sw(5'd7, 5'd6), 1'b1, 1'b0, 1'b0);
    checkCtl("mem_stall", CTL_RAW);
    applyStimulus(1'b1, sw(5'd7, 5'd6), 1'b1, 1'b0, 1'b0);
    checkCtl("mem_go", CTL_RUN);
    checkOutput("mem_cnt", hif.stall_cnt, 16'd3);
    idle(3);

    $display("[TB] branch outranks RAW");
    applyStimulus(1'b1, alu(5'd10, 5'd1, 5'd2), 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, alu(5'd11, 5'd10, 5'd1), 1'b1, 1'b1, 1'b0);
    checkCtl("br_ctl", CTL_FLUSH);
    applyStimulus(1'b1, NOP_I, 1'b0, 1'b0, 1'b0);
    checkOutput("br_state", {14'd0, hif.state}, 16'd3);
    checkOutput("br_flush", hif.flush_cnt, 16'd1);
    checkOutput("br_stall", hif.stall_cnt, 16'd3);
    idle(3);

    $display("[TB] memory freeze during RAW stall");
    applyStimulus(1'b1, alu(5'd12, 5'd1, 5'd2), 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, alu(5'd13, 5'd12, 5'd12), 1'b1, 1'b0, 1'b0);
    checkCtl("frz_raw", CTL_RAW);
    applyStimulus(1'b1, alu(5'd13, 5'd12, 5'd12), 1'b1, 1'b0, 1'b1);
    checkCtl("frz_ctl1", CTL_MEM);
    checkOutput("frz_state_raw", {14'd0, hif.state}, 16'd1);
    applyStimulus(1'b1, alu(5'd13, 5'd12, 5'd12), 1'b1, 1'b0, 1'b1);
    checkCtl("frz_ctl2", CTL_MEM);
    checkOutput("frz_state_mem", {14'd0, hif.state}, 16'd2);
    applyStimulus(1'b1, alu(5'd13, 5'd12, 5'd12), 1'b1, 1'b0, 1'b1);
    checkCtl("frz_ctl3", CTL_MEM);
    checkOutput("frz_cnt", hif.stall_cnt, 16'd4);
    applyStimulus(1'b1, alu(5'd13, 5'd12, 5'd12), 1'b1, 1'b0, 1'b0);
    checkCtl("frz_resume", CTL_RAW);
    checkOutput("frz_state_mem2", {14'd0, hif.state}, 16'd2);
    applyStimulus(1'b1, alu(5'd13, 5'd12, 5'd12), 1'b1, 1'b0, 1'b0);
    checkCtl("frz_go", CTL_RUN);
    checkOutput("frz_cnt_end", hif.stall_cnt, 16'd5);
    checkOutput("frz_state_end", {14'd0, hif.state}, 16'd1);
    idle(3);

    $display("[TB] reset clears scoreboard");
    applyStimulus(1'b1, alu(5'd9, 5'd1, 5'd2), 1'b1, 1'b0, 1'b0);
    checkCtl("rs_issue", CTL_RUN);
    applyStimulus(1'b0, alu(5'd15, 5'd9, 5'd9), 1'b1, 1'b0, 1'b0);
    checkCtl("rs_ctl", CTL_RST);
    applyStimulus(1'b1, alu(5'd15, 5'd9, 5'd9), 1'b1, 1'b0, 1'b0);
    checkCtl("rs_nostall", CTL_RUN);
    checkOutput("rs_stall", hif.stall_cnt, 16'd0);
    checkOutput("rs_flush", hif.flush_cnt, 16'd0);
    checkOutput("rs_state", {14'd0, hif.state}, 16'd0);

    $display("[TB] counter saturation");
    for (int i = 0; i < 65540; i++) applyStimulus(1'b1, NOP_I, 1'b0, 1'b1, 1'b0);
    checkCtl("sat_ctl", CTL_FLUSH);
    applyStimulus(1'b1, NOP_I, 1'b0, 1'b0, 1'b0);
    checkOutput("sat_flush", hif.flush_cnt, 16'hFFFF);
    checkOutput("sat_stall", hif.stall_cnt, 16'd0);
    applyStimulus(1'b1, NOP_I, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, NOP_I, 1'b0, 1'b0, 1'b0);
    checkOutput("sat_hold", hif.flush_cnt, 16'hFFFF);

    $display("Result: errors=%0d of %0d checks", err_cnt, check_cnt);
    $finish;
  end

endmodule
